// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle control sequencer for the MIPS core. Steps the shared
// datapath (one ALU, one unified memory port, IR/A/B/ALUOut registers)
// through fetch, decode, execute, memory and writeback for the subset
// add, sub, and, or, slt, addi, lw, sw, beq and j.
//
// Optional feature macro: MIPS_CTRL_ILLEGAL_TRAP_EN
//   defined   : an unsupported op/funct parks the FSM in HALT (illegal=1)
//               until reset.
//   undefined : an unsupported op/funct gives a one-cycle illegal+retire
//               pulse with no register or memory write, then FETCH.
//
// Memory handshake: MemRd/MemWr act as the request "valid" and are held
// constant for as long as the FSM sits in FETCH, MEM_READ or MEM_WRITE.
// mem_ready is the "ready": the access completes in the cycle where both
// the request and mem_ready are high. mem_ready is ignored in every other
// state.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       PCWr,
   output logic       PCWrCond,
   output logic       IorD,
   output logic       MemRd,
   output logic       MemWr,
   output logic       IRWr,
   output logic       RegDst,
   output logic       RegWr,
   output logic       MemtoReg,
   output logic       ExtOp,
   output logic       ALUsrcA,
   output logic [1:0] ALUsrcB,
   output logic [2:0] ALUctr,
   output logic [1:0] PCsrc,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_EXEC_I    = 4'd4,
      S_ALU_WB    = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WB    = 4'd8,
      S_MEM_WRITE = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd12
   } state_t;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALU operand B selects
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // PC source selects
   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_op;
   logic [5:0] r_funct;
   logic [2:0] w_fn_aluctr;
   logic       w_fn_legal;

   // State register; reset abandons any in-flight access immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_next;
      end
   end

   // Capture op/funct in DECODE so later states do not depend on IR timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= 6'd0;
         r_funct <= 6'd0;
      end else if (r_state == S_DECODE) begin
         r_op    <= op;
         r_funct <= funct;
      end
   end

   // Translate the latched R-type funct into an ALU operation.
   always_comb begin
      w_fn_aluctr = ALU_NOP;
      w_fn_legal  = 1'b1;
      case (r_funct)
         FN_ADD:  w_fn_aluctr = ALU_ADD;
         FN_SUB:  w_fn_aluctr = ALU_SUB;
         FN_AND:  w_fn_aluctr = ALU_AND;
         FN_OR:   w_fn_aluctr = ALU_OR;
         FN_SLT:  w_fn_aluctr = ALU_SLT;
         default: w_fn_legal  = 1'b0;
      endcase
   end

   // Next-state and control outputs; every output defaults to 0.
   always_comb begin
      w_next   = r_state;
      PCWr     = 1'b0;
      PCWrCond = 1'b0;
      IorD     = 1'b0;
      MemRd    = 1'b0;
      MemWr    = 1'b0;
      IRWr     = 1'b0;
      RegDst   = 1'b0;
      RegWr    = 1'b0;
      MemtoReg = 1'b0;
      ExtOp    = 1'b0;
      ALUsrcA  = 1'b0;
      ALUsrcB  = SRCB_B;
      ALUctr   = ALU_NOP;
      PCsrc    = PCSRC_ALU;
      retire   = 1'b0;
      illegal  = 1'b0;

      case (r_state)
         S_RESET: begin
            w_next = S_FETCH;
         end

         S_FETCH: begin
            // PC+4 computed every cycle; IR and PC commit only when the
            // read completes.
            MemRd   = 1'b1;
            IorD    = 1'b0;
            ALUsrcA = 1'b0;
            ALUsrcB = SRCB_FOUR;
            ALUctr  = ALU_ADD;
            PCsrc   = PCSRC_ALU;
            IRWr    = mem_ready;
            PCWr    = mem_ready;
            if (mem_ready) begin
               w_next = S_DECODE;
            end
         end

         S_DECODE: begin
            // Branch target speculatively computed into ALUOut.
            ALUsrcA = 1'b0;
            ALUsrcB = SRCB_IMMSH;
            ExtOp   = 1'b1;
            ALUctr  = ALU_ADD;
            case (op)
               OP_RTYPE:      w_next = S_EXEC_R;
               OP_ADDI:       w_next = S_EXEC_I;
               OP_LW, OP_SW:  w_next = S_MEM_ADDR;
               OP_BEQ:        w_next = S_BRANCH;
               OP_J:          w_next = S_JUMP;
               default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                  w_next = S_HALT;
`else
                  illegal = 1'b1;
                  retire  = 1'b1;
                  w_next  = S_FETCH;
`endif
               end
            endcase
         end

         S_EXEC_R: begin
            ALUsrcA = 1'b1;
            ALUsrcB = SRCB_B;
            ALUctr  = w_fn_aluctr;
            if (w_fn_legal) begin
               w_next = S_ALU_WB;
            end else begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               w_next = S_HALT;
`else
               illegal = 1'b1;
               retire  = 1'b1;
               w_next  = S_FETCH;
`endif
            end
         end

         S_EXEC_I: begin
            ALUsrcA = 1'b1;
            ALUsrcB = SRCB_IMM;
            ExtOp   = 1'b1;
            ALUctr  = ALU_ADD;
            w_next  = S_ALU_WB;
         end

         S_ALU_WB: begin
            // addi writes rt, R-type writes rd.
            RegWr    = 1'b1;
            MemtoReg = 1'b0;
            RegDst   = (r_op == OP_ADDI);
            retire   = 1'b1;
            w_next   = S_FETCH;
         end

         S_MEM_ADDR: begin
            ALUsrcA = 1'b1;
            ALUsrcB = SRCB_IMM;
            ExtOp   = 1'b1;
            ALUctr  = ALU_ADD;
            // Only lw/sw reach this state.
            w_next  = (r_op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end

         S_MEM_READ: begin
            MemRd = 1'b1;
            IorD  = 1'b1;
            if (mem_ready) begin
               w_next = S_MEM_WB;
            end
         end

         S_MEM_WB: begin
            RegWr    = 1'b1;
            RegDst   = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
            w_next   = S_FETCH;
         end

         S_MEM_WRITE: begin
            // The store is the final step, so it retires when accepted.
            MemWr  = 1'b1;
            IorD   = 1'b1;
            retire = mem_ready;
            if (mem_ready) begin
               w_next = S_FETCH;
            end
         end

         S_BRANCH: begin
            ALUsrcA  = 1'b1;
            ALUsrcB  = SRCB_B;
            ALUctr   = ALU_SUB;
            PCWrCond = 1'b1;
            PCsrc    = PCSRC_OUT;
            retire   = 1'b1;
            w_next   = S_FETCH;
         end

         S_JUMP: begin
            PCWr   = 1'b1;
            PCsrc  = PCSRC_JUMP;
            retire = 1'b1;
            w_next = S_FETCH;
         end

         S_HALT: begin
            // Terminal until reset.
            illegal = 1'b1;
            w_next  = S_HALT;
         end

         default: begin
            w_next = S_RESET;
         end
      endcase
   end

   assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Randomized instruction stream checked cycle by cycle against a per-
// instruction table of expected control vectors. Honors
// MIPS_CTRL_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
module tb_mips_multicycle_ctrl;

   localparam int K_R     = 0;
   localparam int K_ADDI  = 1;
   localparam int K_LW    = 2;
   localparam int K_SW    = 3;
   localparam int K_BEQ   = 4;
   localparam int K_J     = 5;
   localparam int K_BADOP = 6;
   localparam int K_BADFN = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       mem_ready = 1'b0;
   logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr;
   logic       MemtoReg, ExtOp, ALUsrcA, retire, illegal;
   logic [1:0] ALUsrcB, PCsrc;
   logic [2:0] ALUctr;
   logic [3:0] dbg_state;
   logic [19:0] w_obs;

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard: one entry per clock cycle.
   logic [19:0] exp_q[$];
   logic        mr_q[$];
   logic [5:0]  op_q[$];
   logic [5:0]  fn_q[$];
   string       tag_q[$];

   logic [5:0] funct_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [2:0] alu_tab   [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

   mips_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
      .IRWr(IRWr), .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
      .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUctr(ALUctr), .PCsrc(PCsrc),
      .retire(retire), .illegal(illegal), .dbg_state(dbg_state)
   );

   assign w_obs = {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg,
                   ExtOp, ALUsrcA, ALUsrcB, ALUctr, PCsrc, retire, illegal};

   // Clock / reset
   always #5 clk = ~clk;

   function automatic logic [19:0] mk(
      input logic pcwr, input logic pcwrcond, input logic iord, input logic memrd,
      input logic memwr, input logic irwr, input logic regdst, input logic regwr,
      input logic memtoreg, input logic extop, input logic srca, input logic [1:0] srcb,
      input logic [2:0] aluctr, input logic [1:0] pcsrc, input logic ret, input logic ill);
      return {pcwr, pcwrcond, iord, memrd, memwr, irwr, regdst, regwr, memtoreg,
              extop, srca, srcb, aluctr, pcsrc, ret, ill};
   endfunction

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %b, expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input string tag, input logic mr, input logic [5:0] o,
                       input logic [5:0] f, input logic [19:0] e);
      tag_q.push_back(tag);
      mr_q.push_back(mr);
      op_q.push_back(o);
      fn_q.push_back(f);
      exp_q.push_back(e);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rnd6();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic [5:0] bad_op();
      logic [5:0] v;
      do v = rnd6();
      while (v == 6'b000000 || v == 6'b001000 || v == 6'b100011 ||
             v == 6'b101011 || v == 6'b000100 || v == 6'b000010);
      return v;
   endfunction

   function automatic logic [5:0] bad_fn();
      logic [5:0] v;
      do v = rnd6();
      while (v == 6'b100000 || v == 6'b100010 || v == 6'b100100 ||
             v == 6'b100101 || v == 6'b101010);
      return v;
   endfunction

   // Reference model: the expected cycle-by-cycle control vectors of one
   // instruction, given its class and the number of memory wait cycles.
   task automatic add_instr(input int kind, input logic [5:0] opv, input logic [5:0] fnv,
                            input logic [2:0] alu_r, input int fw, input int mw);
      logic [19:0] v_fetch_wait, v_fetch_done, v_dec, v_addr, v_halt;
      v_fetch_wait = mk(0,0,0,1,0,0,0,0,0,0,0,2'b01,3'b001,2'b00,0,0);
      v_fetch_done = mk(1,0,0,1,0,1,0,0,0,0,0,2'b01,3'b001,2'b00,0,0);
      v_dec        = mk(0,0,0,0,0,0,0,0,0,1,0,2'b11,3'b001,2'b00,0,0);
      v_addr       = mk(0,0,0,0,0,0,0,0,0,1,1,2'b10,3'b001,2'b00,0,0);
      v_halt       = mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1);
      for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, rnd6(), rnd6(), v_fetch_wait);
      push("fetch", 1'b1, rnd6(), rnd6(), v_fetch_done);
      if (kind == K_BADOP) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         push("decode_badop", rnd_bit(), opv, fnv, v_dec);
         for (int i = 0; i < 4; i++) push("halt_badop", rnd_bit(), opv, fnv, v_halt);
`else
         push("decode_badop", rnd_bit(), opv, fnv, v_dec | 20'b11);
`endif
         return;
      end
      push("decode", rnd_bit(), opv, fnv, v_dec);
      case (kind)
         K_R: begin
            push("exec_r", rnd_bit(), opv, fnv, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,alu_r,2'b00,0,0));
            push("alu_wb_r", rnd_bit(), opv, fnv, mk(0,0,0,0,0,0,0,1,0,0,0,2'b00,3'b000,2'b00,1,0));
         end
         K_BADFN: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            push("exec_badfn", rnd_bit(), opv, fnv, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0,0));
            for (int i = 0; i < 4; i++) push("halt_badfn", rnd_bit(), opv, fnv, v_halt);
`else
            push("exec_badfn", rnd_bit(), opv, fnv, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,1,1));
`endif
         end
         K_ADDI: begin
            push("exec_i", rnd_bit(), opv, fnv, v_addr);
            push("alu_wb_i", rnd_bit(), opv, fnv, mk(0,0,0,0,0,0,1,1,0,0,0,2'b00,3'b000,2'b00,1,0));
         end
         K_LW: begin
            push("mem_addr_lw", rnd_bit(), opv, fnv, v_addr);
            for (int i = 0; i < mw; i++)
               push("mem_read_wait", 1'b0, opv, fnv, mk(0,0,1,1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
            push("mem_read", 1'b1, opv, fnv, mk(0,0,1,1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
            push("mem_wb", rnd_bit(), opv, fnv, mk(0,0,0,0,0,0,1,1,1,0,0,2'b00,3'b000,2'b00,1,0));
         end
         K_SW: begin
            push("mem_addr_sw", rnd_bit(), opv, fnv, v_addr);
            for (int i = 0; i < mw; i++)
               push("mem_write_wait", 1'b0, opv, fnv, mk(0,0,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
            push("mem_write", 1'b1, opv, fnv, mk(0,0,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,0));
         end
         K_BEQ:
            push("branch", rnd_bit(), opv, fnv, mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b01,1,0));
         K_J:
            push("jump", rnd_bit(), opv, fnv, mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0));
         default: ;
      endcase
   endtask

   // Driver: apply n queued cycles (all when n < 0). Entered just after a
   // rising edge; inputs settle before the falling edge where outputs are
   // sampled.
   task automatic drain(input int n);
      int cnt = 0;
      while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
         mem_ready = mr_q.pop_front();
         op        = op_q.pop_front();
         funct     = fn_q.pop_front();
         @(negedge clk);
         check(tag_q.pop_front(), w_obs, exp_q.pop_front());
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = rnd_bit();
      repeat (3) begin
         @(negedge clk);
         check("rst_low", w_obs, 20'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", w_obs, 20'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_instr(input int max_kind);
      int k, idx, fw, mw;
      k  = $urandom_range(0, max_kind);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      idx = $urandom_range(0, 4);
      case (k)
         K_R:     add_instr(K_R, 6'b000000, funct_tab[idx], alu_tab[idx], fw, 0);
         K_ADDI:  add_instr(K_ADDI, 6'b001000, rnd6(), 3'b000, fw, 0);
         K_LW:    add_instr(K_LW, 6'b100011, rnd6(), 3'b000, fw, mw);
         K_SW:    add_instr(K_SW, 6'b101011, rnd6(), 3'b000, fw, mw);
         K_BEQ:   add_instr(K_BEQ, 6'b000100, rnd6(), 3'b000, fw, 0);
         K_J:     add_instr(K_J, 6'b000010, rnd6(), 3'b000, fw, 0);
         K_BADOP: add_instr(K_BADOP, bad_op(), rnd6(), 3'b000, fw, 0);
         default: add_instr(K_BADFN, 6'b000000, bad_fn(), 3'b000, fw, 0);
      endcase
   endtask

   initial begin
      do_reset();

      // Directed: add, lw with two read waits, sw then beq back-to-back.
      add_instr(K_R, 6'b000000, 6'b100000, 3'b001, 0, 0);
      add_instr(K_LW, 6'b100011, rnd6(), 3'b000, 0, 2);
      add_instr(K_SW, 6'b101011, rnd6(), 3'b000, 0, 0);
      add_instr(K_BEQ, 6'b000100, rnd6(), 3'b000, 0, 0);
      add_instr(K_J, 6'b000010, rnd6(), 3'b000, 1, 0);
      drain(-1);

      // Illegal op, then illegal funct.
      add_instr(K_BADOP, 6'b111111, rnd6(), 3'b000, 0, 0);
      drain(-1);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      do_reset();
`endif
      add_instr(K_BADFN, 6'b000000, 6'b000001, 3'b000, 0, 0);
      drain(-1);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      do_reset();
`endif

      // Reset asserted while a store is waiting on mem_ready.
      add_instr(K_SW, 6'b101011, rnd6(), 3'b000, 0, 3);
      drain(4);
      mem_ready = 1'b0;
      #1 check("memwr_before_rst", w_obs, mk(0,0,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
      rst_n = 1'b0;
      #1 check("rst_mid_memwr", w_obs, 20'd0);
      exp_q.delete();
      mr_q.delete();
      op_q.delete();
      fn_q.delete();
      tag_q.delete();
      do_reset();
      add_instr(K_R, 6'b000000, 6'b101010, 3'b101, 0, 0);
      drain(-1);

      // Randomized stream.
      for (int i = 0; i < 60; i++) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         rand_instr(K_J);
`else
         rand_instr(K_BADFN);
`endif
      end
      drain(-1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS core. It replaces single-cycle decode with a state machine that steps the shared datapath (one ALU, one unified memory port, IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback. It supports the core instruction subset (add, sub, and, or, slt, addi, lw, sw, beq, j) and stalls on a ready/valid memory handshake. It sits beside the datapath and drives every datapath enable and mux select.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- op  in  6  IR[31:26]; valid from the DECODE cycle onward
- funct  in  6  IR[5:0]; valid from the DECODE cycle onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWr  out  1  unconditional PC write
- PCWrCond  out  1  PC write if ALU zero
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRd  out  1  memory read request
- MemWr  out  1  memory write request
- IRWr  out  1  instruction register write
- RegDst  out  1  0 = rd (R-type), 1 = rt (I-type)
- RegWr  out  1  register file write
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- ExtOp  out  1  1 = sign-extend imm16
- ALUsrcA  out  1  0 = PC, 1 = A
- ALUsrcB  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- ALUctr  out  3  000 nop, 001 add, 010 sub, 011 and, 100 or, 101 slt
- PCsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  unsupported op/funct was decoded

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT.
- RESET: all outputs 0. Goes to FETCH unconditionally.
- FETCH: MemRd=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUctr=001, PCsrc=00. IRWr=PCWr=mem_ready (Mealy). Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: latches op/funct internally. ALUsrcA=0, ALUsrcB=11, ExtOp=1, ALUctr=001 (branch target into ALUOut). Next state by op:
  - 000000 → EXEC_R
  - 001000 → EXEC_I
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - anything else → illegal handling
- EXEC_R: ALUsrcA=1, ALUsrcB=00. ALUctr from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct → illegal handling. Next state ALU_WB.
- EXEC_I: ALUsrcA=1, ALUsrcB=10, ExtOp=1, ALUctr=001. Next state ALU_WB.
- ALU_WB: RegWr=1, MemtoReg=0, RegDst=0 for R-type and 1 for addi (from latched op). retire=1. Next state FETCH.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ExtOp=1, ALUctr=001. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: MemRd=1, IorD=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: RegWr=1, RegDst=1, MemtoReg=1. retire=1. Next state FETCH.
- MEM_WRITE: MemWr=1, IorD=1. retire=mem_ready. Goes to FETCH on mem_ready.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUctr=010, PCWrCond=1, PCsrc=01. retire=1. Next state FETCH.
- JUMP: PCWr=1, PCsrc=10. retire=1. Next state FETCH.
- Any output not listed for a state is 0.

## Timing
- Latencies with zero-wait memory (FETCH through final state): R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds 1.
- MemRd/MemWr are held constant until the cycle in which mem_ready=1. mem_ready is ignored in all other states.
- rst_n low at any point: state forced to RESET immediately; all outputs 0 while low. The first FETCH is the cycle after the first rising edge with rst_n high. An in-flight access is abandoned with no write strobe.
- retire never asserts in the same cycle as IRWr.

## Configuration
- MIPS_CTRL_ILLEGAL_TRAP_EN defined: illegal handling enters HALT. In HALT, illegal=1, all other outputs are 0, and the FSM stays there until reset.
- MIPS_CTRL_ILLEGAL_TRAP_EN undefined: illegal handling is a one-cycle pulse illegal=1, retire=1 and no register or memory write (NOP), then FETCH. HALT is unreachable.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. Release → RESET, then FETCH asserts MemRd=1, IorD=0.
- R-type add: op=000000, funct=100000, mem_ready=1 → EXEC_R shows ALUctr=001. ALU_WB shows RegWr=1, RegDst=0. retire pulses on cycle 4.
- lw with 2 wait states in MEM_READ → MemRd=1, IorD=1 held for 3 cycles. MEM_WB shows RegWr=1, MemtoReg=1. Total 7 cycles.
- sw then beq back-to-back → MemWr=1 for exactly one cycle, then 3-cycle branch with PCWrCond=1, PCsrc=01, ALUctr=010.
- Illegal op=111111 → with MIPS_CTRL_ILLEGAL_TRAP_EN: illegal stays 1 and MemRd never reasserts. Without it: one-cycle illegal+retire pulse, FETCH next cycle.
- Assert rst_n=0 mid-MEM_WRITE with mem_ready=0 → MemWr drops immediately. Restart begins at FETCH.
